sub_result_stage: RTL and testbench

SUB_RESULT_STAGE -- requirements
Module: sub_result_stage

---
 rtl/sub_pkg.sv | 18 +
 rtl/sub_flags_calc.sv | 17 +
 rtl/sub_result_stage.sv | 73 +++++++
 tb/tb_sub_result_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// sub_pkg: shared data width, flag layout and FIFO entry type for the subtract result stage.
package sub_pkg;
  localparam int DATA_W = 32;
  localparam int FZ = 3;
  localparam int FN = 2;
  localparam int FC = 1;
  localparam int FV = 0;
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;
  typedef struct packed {
    logic [DATA_W-1:0] sub;
    flags_t            flags;
  } entry_t;
endpackage

// File: rtl/sub_flags_calc.sv
// sub_flags_calc: combinational Z/N/C/V flags for a subtraction x - y = sub.
module sub_flags_calc
  import sub_pkg::*;
(
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  input  logic [DATA_W-1:0] sub,
  output flags_t            flags
);
  always_comb begin
    flags = '0;
    flags[FZ] = ~|sub;
    flags[FN] = sub[DATA_W-1];
    flags[FC] = x < y;
    flags[FV] = (x[DATA_W-1] != y[DATA_W-1]) && (sub[DATA_W-1] != x[DATA_W-1]);
  end
endmodule

// File: rtl/sub_result_stage.sv
// sub_result_stage: FIFO of subtractor results with flags captured at push.
// Optional SUB_STATS_EN adds pop and borrow-pop counters.
module sub_result_stage
  import sub_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_x,
  input  logic [DATA_W-1:0]        in_y,
  input  logic [DATA_W-1:0]        in_sub,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_sub,
  output logic [3:0]               out_flags,
  output logic [$clog2(DEPTH):0]   level
`ifdef SUB_STATS_EN
  ,
  output logic [31:0]              stat_total,
  output logic [31:0]              stat_borrow
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  entry_t         mem [DEPTH];
  entry_t         head;
  flags_t         flags;
  logic [AW-1:0]  wr;
  logic [AW-1:0]  rd;
  logic           push;
  logic           pop;
  sub_flags_calc u_calc (
    .x    (in_x),
    .y    (in_y),
    .sub  (in_sub),
    .flags(flags)
  );
  assign in_ready  = level != FULL_LVL;
  assign out_valid = |level;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign head      = mem[rd];
  // Gate the unreset storage so outputs read zero while empty.
  assign out_sub   = out_valid ? head.sub : '0;
  assign out_flags = out_valid ? head.flags : '0;
  always_ff @(posedge clk)
    if (push) mem[wr] <= '{sub: in_sub, flags: flags};
  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      level <= '0;
    end else begin
      if (push) wr <= wr + AW'(1);
      if (pop) rd <= rd + AW'(1);
      level <= level + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
`ifdef SUB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_total  <= '0;
      stat_borrow <= '0;
    end else if (pop) begin
      stat_total  <= stat_total + 32'd1;
      if (head.flags[FC]) stat_borrow <= stat_borrow + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sub_result_stage.sv
// tb_sub_result_stage: directed scoreboard bench for sub_result_stage (DEPTH=4).
module tb_sub_result_stage;
  localparam int DEPTH = 4;
  typedef struct packed {
    logic [31:0] sub;
    logic [3:0]  flags;
  } exp_t;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic [31:0] in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sub;
  logic [3:0]  out_flags;
  logic [2:0]  level;
`ifdef SUB_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_borrow;
  int          exp_total;
  int          exp_borrow;
`endif
  exp_t        sb[$];
  int          exp_level;
  int          n_vec;
  int          n_err;

  sub_result_stage #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_x     (in_x),
    .in_y     (in_y),
    .in_sub   (in_sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sub  (out_sub),
    .out_flags(out_flags),
    .level    (level)
`ifdef SUB_STATS_EN
    ,
    .stat_total (stat_total),
    .stat_borrow(stat_borrow)
`endif
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model_flags(logic [31:0] x, logic [31:0] y, logic [31:0] s);
    return {s == 32'd0, s[31], x < y, (x[31] != y[31]) && (s[31] != x[31])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y);
    in_valid = 1;
    in_x     = x;
    in_y     = y;
    in_sub   = x - y;
  endtask

  // Check state, update scoreboard from the modelled handshake, advance one cycle.
  task automatic tick();
    exp_t e;
    logic push, pop;
    if (rst) begin
      sb.delete();
      exp_level = 0;
`ifdef SUB_STATS_EN
      exp_total  = 0;
      exp_borrow = 0;
`endif
    end else begin
      chk("level", 32'(level), 32'(exp_level));
      chk("in_ready", 32'(in_ready), 32'(exp_level != DEPTH));
      chk("out_valid", 32'(out_valid), 32'(exp_level != 0));
`ifdef SUB_STATS_EN
      chk("stat_total", stat_total, 32'(exp_total));
      chk("stat_borrow", stat_borrow, 32'(exp_borrow));
`endif
      if (sb.size() != 0) begin
        chk("head_sub", out_sub, sb[0].sub);
        chk("head_flags", 32'(out_flags), 32'(sb[0].flags));
      end
      pop  = exp_level != 0 && out_ready;
      push = in_valid && exp_level != DEPTH;
      if (pop) begin
        e = sb.pop_front();
`ifdef SUB_STATS_EN
        exp_total++;
        if (e.flags[1]) exp_borrow++;
`endif
      end
      if (push) sb.push_back({in_sub, model_flags(in_x, in_y, in_sub)});
      exp_level = exp_level + int'(push) - int'(pop);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_level = 0;
    rst = 1;
    in_valid = 0;
    in_x = 0;
    in_y = 0;
    in_sub = 0;
    out_ready = 0;
    @(negedge clk);
    tick();
    tick();
    rst = 0;
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_sub", out_sub, 0);
    chk("rst_out_flags", 32'(out_flags), 0);
    // Basic positive result
    out_ready = 1;
    drive(5, 3);
    tick();
    in_valid = 0;
    chk("basic_sub", out_sub, 32'h2);
    chk("basic_flags", 32'(out_flags), 32'b0000);
    tick();
    // Negative with borrow, then zero
    out_ready = 0;
    drive(3, 5);
    tick();
    in_valid = 0;
    chk("neg_sub", out_sub, 32'hFFFF_FFFE);
    chk("neg_flags", 32'(out_flags), 32'b0110);
    out_ready = 1;
    drive(7, 7);
    tick();
    in_valid = 0;
    chk("zero_flags", 32'(out_flags), 32'b1000);
    tick();
    // Signed overflow
    drive(32'h8000_0000, 32'h1);
    tick();
    in_valid = 0;
    chk("ovf_sub", out_sub, 32'h7FFF_FFFF);
    chk("ovf_flags", 32'(out_flags), 32'b0001);
    tick();
    // Fill to FULL, attempt extra pushes, then drain
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive($urandom, $urandom);
      tick();
    end
    chk("full_level", 32'(level), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    drive(32'h1234, 32'h5678);
    tick();
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("full_pop_only", 32'(level), 3);
    for (int i = 0; i < 3; i++) tick();
    chk("drain_level", 32'(level), 0);
    // Steady push+pop across pointer wrap
    out_ready = 0;
    drive(100, 1);
    tick();
    drive(1, 100);
    tick();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      drive($urandom, $urandom);
      tick();
      chk("stream_level", 32'(level), 2);
    end
    in_valid = 0;
    tick();
    tick();
    // Random mix including corner operands
    for (int i = 0; i < 40; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin in_x = $urandom; in_y = in_x; end
        1: begin in_x = 32'h7FFF_FFFF; in_y = 32'hFFFF_FFFF; end
        default: begin in_x = $urandom; in_y = $urandom; end
      endcase
      in_sub = in_x - in_y;
      tick();
    end
    // Reset mid-operation overrides push/pop
    in_valid = 0;
    out_ready = 1;
    tick();
    tick();
    tick();
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, $urandom);
      tick();
    end
    chk("pre_rst_level", 32'(level), 3);
    rst = 1;
    out_ready = 1;
    tick();
    rst = 0;
    in_valid = 0;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
`ifdef SUB_STATS_EN
    chk("mid_rst_total", stat_total, 0);
    chk("mid_rst_borrow", stat_borrow, 0);
`endif
    drive(9, 4);
    tick();
    in_valid = 0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
